// File: rtl/ccc_rst_pkg.sv
// Shared types and helpers for the CCC lock qualifier / staged reset sequencer.
package ccc_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // One counter serves both the lock filter and the stage delay, so size it for the larger.
  function automatic int cnt_width(input int lock_filter, input int stage_delay);
    int m;
    m = (lock_filter > stage_delay) ? lock_filter : stage_delay;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop synchroniser for the asynchronous CCC lock, cleared by the fabric reset.
module ccc_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Qualifies CCC lock and releases fabric resets in stages; any loss of qualified
// lock re-asserts every reset and is counted.
module ccc_lock_reset_seq
  import ccc_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int STAGE_DELAY = 64,
  parameter int NUM_STAGES  = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  FAB_CLK,
  input  logic                  FAB_RST,
  input  logic                  LOCK_IN,
  input  logic                  BYPASS_LOCK,
  input  logic                  SW_RST_REQ,
  output logic [NUM_STAGES-1:0] RST_OUT,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [CNT_W-1:0]      LOSS_COUNT,
  output logic [1:0]            STATE
);

  localparam int CW    = cnt_width(LOCK_FILTER, STAGE_DELAY);
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0]    FILT_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0]    DLY_LAST   = CW'(STAGE_DELAY - 1);
  localparam logic [STG_W-1:0] STAGE_LAST = STG_W'(NUM_STAGES - 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [STG_W-1:0]        stage, stage_nxt;
  logic [NUM_STAGES-1:0]   rst_nxt;
  logic                    ready_nxt, lost_nxt;
  logic [CNT_W-1:0]        loss_nxt;
  logic                    lock_q, lock_ok;

  ccc_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (FAB_CLK),
    .rst (FAB_RST),
    .d   (LOCK_IN),
    .q   (lock_q)
  );

  // The bypass strap is static, so it is deliberately not synchronised.
  assign lock_ok = lock_q | BYPASS_LOCK;

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RST) begin
      state      <= HOLD;
      cnt        <= '0;
      stage      <= '0;
      RST_OUT    <= '1;
      READY      <= 1'b0;
      LOCK_LOST  <= 1'b0;
      LOSS_COUNT <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      stage      <= stage_nxt;
      RST_OUT    <= rst_nxt;
      READY      <= ready_nxt;
      LOCK_LOST  <= lost_nxt;
      LOSS_COUNT <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stage_nxt = stage;
    rst_nxt   = RST_OUT;
    ready_nxt = READY;
    lost_nxt  = 1'b0;
    loss_nxt  = LOSS_COUNT;
    case (state)
      HOLD: begin
        rst_nxt   = '1;
        ready_nxt = 1'b0;
        cnt_nxt   = '0;
        stage_nxt = '0;
        if (lock_ok) state_nxt = FILTER;
      end
      FILTER: begin
        if (!lock_ok || SW_RST_REQ) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (cnt == FILT_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          stage_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_ok || SW_RST_REQ) begin
          state_nxt = HOLD;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          cnt_nxt   = '0;
          stage_nxt = '0;
          // Lock loss takes priority over a software request: it alone pulses and counts.
          if (!lock_ok) begin
            lost_nxt = 1'b1;
            if (LOSS_COUNT != '1) loss_nxt = LOSS_COUNT + 1'b1;
          end
        end else if (state == RELEASE) begin
          if (cnt == DLY_LAST) begin
            // Stages clear strictly in order from bit 0, so a shift releases the next one.
            rst_nxt = RST_OUT << 1;
            cnt_nxt = '0;
            if (stage == STAGE_LAST) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
              stage_nxt = '0;
            end else begin
              stage_nxt = stage + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  assign STATE = state;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench: two sequencer instances (defaults, and a short/saturating variant) against an elapsed-time model.
module tb_ccc_lock_reset_seq;

  typedef struct packed { int ss; int lf; int sd; int ns; int cw; } prm_t;
  typedef struct packed { logic [7:0] hist; logic seq; int el; int loss; logic lost; } mdl_t;

  localparam prm_t PA = '{ss: 2, lf: 16, sd: 64, ns: 3, cw: 8};
  localparam prm_t PB = '{ss: 3, lf: 3,  sd: 4,  ns: 2, cw: 2};

  logic FAB_CLK = 1'b0;
  logic FAB_RST = 1'b1, LOCK_IN = 1'b0, BYPASS_LOCK = 1'b0, SW_RST_REQ = 1'b0;
  logic [2:0] rst_a; logic rdy_a, lost_a; logic [7:0] cnt_a; logic [1:0] st_a;
  logic [1:0] rst_b; logic rdy_b, lost_b; logic [1:0] cnt_b; logic [1:0] st_b;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0;
  mdl_t ma, mb;

  always #5 FAB_CLK = ~FAB_CLK;

  ccc_lock_reset_seq u_dut (
    .FAB_CLK(FAB_CLK), .FAB_RST(FAB_RST), .LOCK_IN(LOCK_IN), .BYPASS_LOCK(BYPASS_LOCK),
    .SW_RST_REQ(SW_RST_REQ), .RST_OUT(rst_a), .READY(rdy_a), .LOCK_LOST(lost_a),
    .LOSS_COUNT(cnt_a), .STATE(st_a)
  );

  ccc_lock_reset_seq #(.SYNC_STAGES(3), .LOCK_FILTER(3), .STAGE_DELAY(4), .NUM_STAGES(2), .CNT_W(2)) u_sat (
    .FAB_CLK(FAB_CLK), .FAB_RST(FAB_RST), .LOCK_IN(LOCK_IN), .BYPASS_LOCK(BYPASS_LOCK),
    .SW_RST_REQ(SW_RST_REQ), .RST_OUT(rst_b), .READY(rdy_b), .LOCK_LOST(lost_b),
    .LOSS_COUNT(cnt_b), .STATE(st_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a sequence is "live" from the edge qualified lock is first seen in HOLD;
  // everything else follows from the number of edges elapsed since then.
  function automatic int released(mdl_t m, prm_t p);
    int r;
    if (!m.seq || m.el < p.lf) return 0;
    r = (m.el - p.lf) / p.sd;
    return (r > p.ns) ? p.ns : r;
  endfunction

  function automatic int phase(mdl_t m, prm_t p);
    if (!m.seq) return 0;
    if (m.el < p.lf) return 1;
    if (released(m, p) < p.ns) return 2;
    return 3;
  endfunction

  function automatic int exp_rst(mdl_t m, prm_t p);
    int all;
    all = (1 << p.ns) - 1;
    return all & ~((1 << released(m, p)) - 1);
  endfunction

  function automatic mdl_t step(mdl_t m, prm_t p, logic rst, logic li, logic byp, logic sw);
    mdl_t n;
    logic lok;
    int ph;
    n = m;
    if (rst) begin
      n.hist = '0; n.seq = 1'b0; n.el = 0; n.loss = 0; n.lost = 1'b0;
      return n;
    end
    lok = m.hist[p.ss-1] | byp;
    ph = phase(m, p);
    n.lost = 1'b0;
    if (ph == 0) begin
      if (lok) begin n.seq = 1'b1; n.el = 0; end
    end else if (ph == 1) begin
      if (!lok || sw) n.seq = 1'b0;
      else n.el = m.el + 1;
    end else begin
      if (!lok) begin
        n.seq = 1'b0;
        n.lost = 1'b1;
        if (m.loss < (1 << p.cw) - 1) n.loss = m.loss + 1;
      end else if (sw) n.seq = 1'b0;
      else n.el = m.el + 1;
    end
    n.hist = {m.hist[6:0], li};
    return n;
  endfunction

  always @(posedge FAB_CLK) begin
    cyc++;
    ma = step(ma, PA, FAB_RST, LOCK_IN, BYPASS_LOCK, SW_RST_REQ);
    mb = step(mb, PB, FAB_RST, LOCK_IN, BYPASS_LOCK, SW_RST_REQ);
    #2;
    if (chk_en) begin
      chk("a_rst_out", 32'(rst_a), 32'(exp_rst(ma, PA)));
      chk("a_ready", 32'(rdy_a), 32'(phase(ma, PA) == 3));
      chk("a_lock_lost", 32'(lost_a), 32'(ma.lost));
      chk("a_loss_count", 32'(cnt_a), 32'(ma.loss));
      chk("a_state", 32'(st_a), 32'(phase(ma, PA)));
      chk("b_rst_out", 32'(rst_b), 32'(exp_rst(mb, PB)));
      chk("b_ready", 32'(rdy_b), 32'(phase(mb, PB) == 3));
      chk("b_lock_lost", 32'(lost_b), 32'(mb.lost));
      chk("b_loss_count", 32'(cnt_b), 32'(mb.loss));
      chk("b_state", 32'(st_b), 32'(phase(mb, PB)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge FAB_CLK);
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge FAB_CLK);
  endtask

  task automatic do_reset(input int n);
    FAB_RST = 1'b1; SW_RST_REQ = 1'b0;
    tick(n);
    FAB_RST = 1'b0;
  endtask

  initial begin
    int e0, e1, f, len;
    // Reset values and nominal release timing (82 / 146 / 210).
    tick(5);
    chk_en = 1'b1;
    chk("rst_out_reset", 32'(rst_a), 32'd7);
    chk("ready_reset", 32'(rdy_a), 32'd0);
    chk("loss_count_reset", 32'(cnt_a), 32'd0);
    chk("state_reset", 32'(st_a), 32'd0);
    FAB_RST = 1'b0; LOCK_IN = 1'b1; e0 = cyc + 1;
    wait_to(e0 + 81);  chk("rst_out_e81", 32'(rst_a), 32'd7);
    wait_to(e0 + 82);  chk("rst_out_e82", 32'(rst_a), 32'd6);
    wait_to(e0 + 145); chk("rst_out_e145", 32'(rst_a), 32'd6);
    wait_to(e0 + 146); chk("rst_out_e146", 32'(rst_a), 32'd4);
    wait_to(e0 + 209); chk("ready_e209", 32'(rdy_a), 32'd0);
    wait_to(e0 + 210); chk("rst_out_e210", 32'(rst_a), 32'd0);
    chk("ready_e210", 32'(rdy_a), 32'd1);

    // Lock glitch during FILTER: back to HOLD quietly, timing restarts from re-rise.
    LOCK_IN = 1'b0; do_reset(2);
    LOCK_IN = 1'b1; e0 = cyc + 1;
    wait_to(e0 + 9);  LOCK_IN = 1'b0;
    wait_to(e0 + 12); LOCK_IN = 1'b1; e1 = cyc + 1;
    chk("state_after_glitch", 32'(st_a), 32'd0);
    chk("lost_after_glitch", 32'(lost_a), 32'd0);
    wait_to(e1 + 81); chk("rst_out_restart_81", 32'(rst_a), 32'd7);
    wait_to(e1 + 82); chk("rst_out_restart_82", 32'(rst_a), 32'd6);
    wait_to(e1 + 215);

    // Lock loss in RUN: visible two edges after the sampling edge.
    LOCK_IN = 1'b0; f = cyc + 1;
    wait_to(f + 1); chk("ready_f1", 32'(rdy_a), 32'd1);
    wait_to(f + 2);
    chk("rst_out_loss", 32'(rst_a), 32'd7);
    chk("ready_loss", 32'(rdy_a), 32'd0);
    chk("lock_lost_pulse", 32'(lost_a), 32'd1);
    chk("loss_count_1", 32'(cnt_a), 32'd1);
    wait_to(f + 3); chk("lock_lost_end", 32'(lost_a), 32'd0);

    // Repeated loss: narrow counter saturates.
    do_reset(2);
    repeat (5) begin
      LOCK_IN = 1'b1; tick(40);
      LOCK_IN = 1'b0; tick(5);
    end
    tick(5);
    chk("loss_count_5", 32'(cnt_a), 32'd5);
    chk("loss_count_sat", 32'(cnt_b), 32'd3);

    // Bypass strap with lock tied low, then a software re-sequence from RUN.
    BYPASS_LOCK = 1'b1; LOCK_IN = 1'b0; do_reset(2);
    tick(220);
    chk("bypass_ready", 32'(rdy_a), 32'd1);
    chk("bypass_rst_out", 32'(rst_a), 32'd0);
    SW_RST_REQ = 1'b1; tick(1); SW_RST_REQ = 1'b0;
    chk("sw_state", 32'(st_a), 32'd0);
    chk("sw_rst_out", 32'(rst_a), 32'd7);
    chk("sw_no_lost", 32'(lost_a), 32'd0);
    tick(220);
    chk("sw_rerun_ready", 32'(rdy_a), 32'd1);

    // Lock loss and software request on the same edge in RELEASE; then FAB_RST mid-RELEASE.
    BYPASS_LOCK = 1'b0; LOCK_IN = 1'b1; do_reset(2);
    e0 = cyc + 1;
    wait_to(e0 + 40); LOCK_IN = 1'b0; f = cyc + 1;
    wait_to(f + 1);   SW_RST_REQ = 1'b1;
    wait_to(f + 2);   SW_RST_REQ = 1'b0;
    chk("both_lost", 32'(lost_a), 32'd1);
    chk("both_count", 32'(cnt_a), 32'd1);
    LOCK_IN = 1'b1; tick(40);
    chk("mid_release_state", 32'(st_a), 32'd2);
    FAB_RST = 1'b1; tick(1); FAB_RST = 1'b0;
    chk("fab_rst_rst_out", 32'(rst_a), 32'd7);
    chk("fab_rst_count", 32'(cnt_a), 32'd0);
    chk("fab_rst_state", 32'(st_a), 32'd0);

    // Random lock activity, software requests, strap changes and occasional resets.
    for (int i = 0; i < 200; i++) begin
      LOCK_IN = ($urandom_range(0, 3) != 0);
      BYPASS_LOCK = ($urandom_range(0, 15) == 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 300);
      for (int j = 0; j < len; j++) begin
        SW_RST_REQ = ($urandom_range(0, 299) == 0);
        FAB_RST = ($urandom_range(0, 1999) == 0);
        tick(1);
      end
    end
    FAB_RST = 1'b0; SW_RST_REQ = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
